// File: rtl/adder_arb_pkg.sv
// Shared types, default sizes and the round-robin scan used by the adder arbiter.
package adder_arb_pkg;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_NUM_REQ = 4;
   localparam int MAX_REQ     = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // Priority scan of valid starting at start, wrapping at num; the first set bit wins.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                     input int unsigned         num,
                                     input int unsigned         start);
      pick_t       p;
      int unsigned idx;
      p = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = start + k;
         if (idx >= num) idx = idx - num;
         if ((k < num) && !p.found && valid[idx[2:0]]) begin
            p.found = 1'b1;
            p.idx   = idx[2:0];
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder; the shared datapath behind the arbiter.
module ripple_carry_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin sharing of one adder among NUM_REQ add/subtract requesters,
// with a single-entry result buffer tagged by requester index.
//
// state | meaning
// EMPTY | result buffer free, res_valid = 0
// FULL  | result buffer holds a result, res_valid = 1
module adder_rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDW     = 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_sub,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_sum,
   output logic                     res_cout,
   output logic [IDW-1:0]           res_id
);

   state_t             state, state_nx;
   logic [IDW-1:0]     ptr;
   logic [IDW-1:0]     winner;
   pick_t              pick;
   logic               can_accept;
   logic               accept;
   logic [NUM_REQ-1:0] grant;

   logic [WIDTH-1:0]   a_arr [NUM_REQ];
   logic [WIDTH-1:0]   b_arr [NUM_REQ];
   logic [WIDTH-1:0]   add_a, add_b, add_sum;
   logic               add_cin, add_cout;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
      assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
   end

   assign pick = rr_pick(MAX_REQ'(req_valid), NUM_REQ, {{(32-IDW){1'b0}}, ptr});

   always_comb begin
      winner = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick.idx == 3'(i)) winner = IDW'(i);
      end
   end

   assign can_accept = (state == EMPTY) | res_ready;
   assign grant      = pick.found ? (NUM_REQ'(1) << winner) : '0;
   // Reset gates the grant so nothing is offered while the block is held in reset.
   assign accept     = pick.found & can_accept & resetn;

   assign add_a   = a_arr[winner];
   assign add_b   = req_sub[winner] ? ~b_arr[winner] : b_arr[winner];
   assign add_cin = req_sub[winner];

   ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= EMPTY;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (accept)                          state_nx = FULL;
      else if (state == FULL && res_ready) state_nx = EMPTY;
   end

   always_comb begin
      res_valid = (state == FULL);
      req_ready = grant & {NUM_REQ{can_accept & resetn}};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr      <= '0;
         res_sum  <= '0;
         res_cout <= 1'b0;
         res_id   <= '0;
      end else if (accept) begin
         ptr      <= (winner == IDW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
         res_sum  <= add_sum;
         res_cout <= add_cout;
         res_id   <= winner;
      end
   end

endmodule
